// File: rtl/alu_reservation_station_if.sv
// Dispatch / CDB / issue bus of the ALU reservation station.
//  slave  : station side (takes dispatch, CDB and ALU-ready; drives disp_ready and issue slot)
//  master : producer side (dispatch stage, CDB source and ALU)
interface alu_reservation_station_if #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 5
);
  logic             in_disp_valid;
  logic             out_disp_ready;
  logic [OP_W-1:0]  in_disp_op;
  logic [TAG_W-1:0] in_disp_dst_tag;
  logic [63:0]      in_disp_val_a, in_disp_val_b;
  logic [TAG_W-1:0] in_disp_tag_a, in_disp_tag_b;
  logic             in_disp_rdy_a, in_disp_rdy_b;
  logic [3:0]       in_disp_nzcv;
  logic [TAG_W-1:0] in_disp_nzcv_tag;
  logic             in_disp_nzcv_rdy;
  logic [5:0]       in_disp_imms, in_disp_immr;
  logic [3:0]       in_disp_cond;

  logic             in_cdb_valid;
  logic [TAG_W-1:0] in_cdb_tag;
  logic [63:0]      in_cdb_value;
  logic             in_cdb_set_nzcv;
  logic [3:0]       in_cdb_nzcv;

  logic             in_alu_ready;
  logic             out_issue_valid;
  logic [OP_W-1:0]  out_issue_op;
  logic [TAG_W-1:0] out_issue_dst_tag;
  logic [63:0]      out_issue_val_a, out_issue_val_b;
  logic [3:0]       out_issue_nzcv;
  logic [5:0]       out_issue_imms, out_issue_immr;
  logic [3:0]       out_issue_cond;

  modport slave (
    input  in_disp_valid, in_disp_op, in_disp_dst_tag, in_disp_val_a, in_disp_val_b,
           in_disp_tag_a, in_disp_tag_b, in_disp_rdy_a, in_disp_rdy_b, in_disp_nzcv,
           in_disp_nzcv_tag, in_disp_nzcv_rdy, in_disp_imms, in_disp_immr, in_disp_cond,
           in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_set_nzcv, in_cdb_nzcv, in_alu_ready,
    output out_disp_ready, out_issue_valid, out_issue_op, out_issue_dst_tag, out_issue_val_a,
           out_issue_val_b, out_issue_nzcv, out_issue_imms, out_issue_immr, out_issue_cond
  );

  modport master (
    output in_disp_valid, in_disp_op, in_disp_dst_tag, in_disp_val_a, in_disp_val_b,
           in_disp_tag_a, in_disp_tag_b, in_disp_rdy_a, in_disp_rdy_b, in_disp_nzcv,
           in_disp_nzcv_tag, in_disp_nzcv_rdy, in_disp_imms, in_disp_immr, in_disp_cond,
           in_cdb_valid, in_cdb_tag, in_cdb_value, in_cdb_set_nzcv, in_cdb_nzcv, in_alu_ready,
    input  out_disp_ready, out_issue_valid, out_issue_op, out_issue_dst_tag, out_issue_val_a,
           out_issue_val_b, out_issue_nzcv, out_issue_imms, out_issue_immr, out_issue_cond
  );
endinterface

// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched micro-ops until A, B and NZCV are available,
// snoops the CDB for missing operands, and issues the oldest ready entry into a registered
// output slot.
//  in_clk   : clock
//  in_rst   : synchronous active-high reset
//  in_flush : squash all entries and the output slot
//  bus      : dispatch, CDB and issue signals (slave side)
module alu_reservation_station #(
  parameter int NUM_ENTRIES = 4,
  parameter int TAG_W       = 4,
  parameter int OP_W        = 5
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_flush,
  alu_reservation_station_if.slave bus
);
  localparam int CW = $clog2(NUM_ENTRIES) + 1;
  localparam int IW = $clog2(NUM_ENTRIES);

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dst;
    logic [63:0]      va, vb;
    logic [TAG_W-1:0] ta, tb;
    logic             ra, rb;
    logic [3:0]       nz;
    logic [TAG_W-1:0] tnz;
    logic             rnz;
    logic [5:0]       imms, immr;
    logic [3:0]       cond;
  } ent_t;

  typedef struct packed {
    logic [OP_W-1:0]  op;
    logic [TAG_W-1:0] dst;
    logic [63:0]      va, vb;
    logic [3:0]       nz;
    logic [5:0]       imms, immr;
    logic [3:0]       cond;
  } out_t;

  ent_t                   r_ent [NUM_ENTRIES];
  logic [CW-1:0]          r_age [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_vld;
  logic                   r_out_vld;
  out_t                   r_out;

  logic [NUM_ENTRIES-1:0] w_rdy;
  logic [CW-1:0]          w_cnt, w_sel_age;
  logic [IW-1:0]          w_alloc_idx, w_sel_idx;
  logic                   w_sel_any, w_issue, w_disp_acc;
  ent_t                   w_new;
  logic                   w_hit_a, w_hit_b, w_hit_nz;

  always_comb begin
    w_cnt       = '0;
    w_alloc_idx = '0;
    w_sel_any   = 1'b0;
    w_sel_idx   = '0;
    w_sel_age   = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      w_rdy[i] = r_vld[i] & r_ent[i].ra & r_ent[i].rb & r_ent[i].rnz;
      w_cnt    = w_cnt + CW'(r_vld[i]);
    end
    // Descending scan so the lowest free index wins.
    for (int i = NUM_ENTRIES - 1; i >= 0; i--)
      if (!r_vld[i]) w_alloc_idx = IW'(i);
    // Oldest ready entry = largest age; ages of valid entries are unique.
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (w_rdy[i] && (!w_sel_any || r_age[i] > w_sel_age)) begin
        w_sel_any = 1'b1;
        w_sel_idx = IW'(i);
        w_sel_age = r_age[i];
      end
  end

  // Readiness is judged on registered state, so an issue only frees its slot next cycle.
  assign bus.out_disp_ready = (w_cnt < CW'(NUM_ENTRIES));
  assign w_disp_acc         = bus.in_disp_valid & bus.out_disp_ready;
  assign w_issue            = w_sel_any & (~r_out_vld | bus.in_alu_ready);

  // Same-cycle CDB bypass into the entry being dispatched.
  assign w_hit_a  = bus.in_cdb_valid && (bus.in_cdb_tag == bus.in_disp_tag_a);
  assign w_hit_b  = bus.in_cdb_valid && (bus.in_cdb_tag == bus.in_disp_tag_b);
  assign w_hit_nz = bus.in_cdb_valid && bus.in_cdb_set_nzcv && (bus.in_cdb_tag == bus.in_disp_nzcv_tag);

  always_comb begin
    w_new      = '0;
    w_new.op   = bus.in_disp_op;
    w_new.dst  = bus.in_disp_dst_tag;
    w_new.ta   = bus.in_disp_tag_a;
    w_new.tb   = bus.in_disp_tag_b;
    w_new.tnz  = bus.in_disp_nzcv_tag;
    w_new.imms = bus.in_disp_imms;
    w_new.immr = bus.in_disp_immr;
    w_new.cond = bus.in_disp_cond;
    w_new.ra   = bus.in_disp_rdy_a | w_hit_a;
    w_new.va   = bus.in_disp_rdy_a ? bus.in_disp_val_a : bus.in_cdb_value;
    w_new.rb   = bus.in_disp_rdy_b | w_hit_b;
    w_new.vb   = bus.in_disp_rdy_b ? bus.in_disp_val_b : bus.in_cdb_value;
    w_new.rnz  = bus.in_disp_nzcv_rdy | w_hit_nz;
    w_new.nz   = bus.in_disp_nzcv_rdy ? bus.in_disp_nzcv : bus.in_cdb_nzcv;
  end

  always_ff @(posedge in_clk) begin
    if (in_rst || in_flush) begin
      r_vld     <= '0;
      r_out_vld <= 1'b0;
      r_out     <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_ent[i] <= '0;
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (r_vld[i]) begin
          if (w_issue && w_sel_idx == IW'(i)) begin
            r_vld[i] <= 1'b0;
          end else begin
            if (!r_ent[i].ra && bus.in_cdb_valid && bus.in_cdb_tag == r_ent[i].ta) begin
              r_ent[i].ra <= 1'b1;
              r_ent[i].va <= bus.in_cdb_value;
            end
            if (!r_ent[i].rb && bus.in_cdb_valid && bus.in_cdb_tag == r_ent[i].tb) begin
              r_ent[i].rb <= 1'b1;
              r_ent[i].vb <= bus.in_cdb_value;
            end
            if (!r_ent[i].rnz && bus.in_cdb_valid && bus.in_cdb_set_nzcv &&
                bus.in_cdb_tag == r_ent[i].tnz) begin
              r_ent[i].rnz <= 1'b1;
              r_ent[i].nz  <= bus.in_cdb_nzcv;
            end
            // Dispatch ages everyone; issue closes the gap above the departing entry.
            r_age[i] <= r_age[i] + CW'(w_disp_acc) - CW'(w_issue && (r_age[i] > w_sel_age));
          end
        end else if (w_disp_acc && w_alloc_idx == IW'(i)) begin
          r_vld[i] <= 1'b1;
          r_ent[i] <= w_new;
          r_age[i] <= '0;
        end
      end

      if (w_issue) begin
        r_out_vld  <= 1'b1;
        r_out.op   <= r_ent[w_sel_idx].op;
        r_out.dst  <= r_ent[w_sel_idx].dst;
        r_out.va   <= r_ent[w_sel_idx].va;
        r_out.vb   <= r_ent[w_sel_idx].vb;
        r_out.nz   <= r_ent[w_sel_idx].nz;
        r_out.imms <= r_ent[w_sel_idx].imms;
        r_out.immr <= r_ent[w_sel_idx].immr;
        r_out.cond <= r_ent[w_sel_idx].cond;
      end else if (bus.in_alu_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign bus.out_issue_valid   = r_out_vld;
  assign bus.out_issue_op      = r_out.op;
  assign bus.out_issue_dst_tag = r_out.dst;
  assign bus.out_issue_val_a   = r_out.va;
  assign bus.out_issue_val_b   = r_out.vb;
  assign bus.out_issue_nzcv    = r_out.nz;
  assign bus.out_issue_imms    = r_out.imms;
  assign bus.out_issue_immr    = r_out.immr;
  assign bus.out_issue_cond    = r_out.cond;
endmodule

// File: tb/tb_alu_reservation_station.sv
// Scoreboard bench for alu_reservation_station: expected issue records are queued when the
// stimulus that makes them issuable is driven, and popped when the ALU takes the slot.
module tb_alu_reservation_station;
  logic in_clk = 1'b0;
  logic in_rst, in_flush;
  always #5 in_clk = ~in_clk;

  alu_reservation_station_if #(.TAG_W(4), .OP_W(5)) bus ();
  alu_reservation_station #(.NUM_ENTRIES(4), .TAG_W(4), .OP_W(5)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_flush(in_flush), .bus(bus));

  typedef struct packed {
    logic [4:0]  op;
    logic [3:0]  dst;
    logic [63:0] a, b;
    logic [3:0]  nz;
    logic [5:0]  imms, immr;
    logic [3:0]  cond;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Side fields are derived from the destination tag so each record is distinguishable.
  function automatic logic [4:0] f_op(input logic [3:0] d);   return {1'b1, d} ^ 5'h0a;    endfunction
  function automatic logic [5:0] f_imms(input logic [3:0] d); return {2'b01, d};           endfunction
  function automatic logic [5:0] f_immr(input logic [3:0] d); return {d, 2'b10};           endfunction
  function automatic logic [3:0] f_cond(input logic [3:0] d); return ~d;                   endfunction

  task automatic push_exp(input logic [3:0] d, input logic [63:0] a, b, input logic [3:0] nz);
    sb_q.push_back('{op: f_op(d), dst: d, a: a, b: b, nz: nz,
                     imms: f_imms(d), immr: f_immr(d), cond: f_cond(d)});
  endtask

  task automatic idle();
    bus.in_disp_valid = 0; bus.in_disp_op = '0; bus.in_disp_dst_tag = '0;
    bus.in_disp_val_a = '0; bus.in_disp_val_b = '0; bus.in_disp_tag_a = '0; bus.in_disp_tag_b = '0;
    bus.in_disp_rdy_a = 0; bus.in_disp_rdy_b = 0; bus.in_disp_nzcv = '0; bus.in_disp_nzcv_tag = '0;
    bus.in_disp_nzcv_rdy = 0; bus.in_disp_imms = '0; bus.in_disp_immr = '0; bus.in_disp_cond = '0;
    bus.in_cdb_valid = 0; bus.in_cdb_tag = '0; bus.in_cdb_value = '0;
    bus.in_cdb_set_nzcv = 0; bus.in_cdb_nzcv = '0;
    in_flush = 0;
  endtask

  task automatic drv_disp(input logic [3:0] d, input logic [63:0] a, b,
                          input logic ra, input logic [3:0] ta, input logic rb, input logic [3:0] tb_,
                          input logic [3:0] nz, input logic nrdy, input logic [3:0] ntag);
    bus.in_disp_valid = 1; bus.in_disp_op = f_op(d); bus.in_disp_dst_tag = d;
    bus.in_disp_val_a = a; bus.in_disp_val_b = b;
    bus.in_disp_rdy_a = ra; bus.in_disp_tag_a = ta; bus.in_disp_rdy_b = rb; bus.in_disp_tag_b = tb_;
    bus.in_disp_nzcv = nz; bus.in_disp_nzcv_rdy = nrdy; bus.in_disp_nzcv_tag = ntag;
    bus.in_disp_imms = f_imms(d); bus.in_disp_immr = f_immr(d); bus.in_disp_cond = f_cond(d);
  endtask

  task automatic cdb(input logic [3:0] t, input logic [63:0] v, input logic setf, input logic [3:0] nz);
    bus.in_cdb_valid = 1; bus.in_cdb_tag = t; bus.in_cdb_value = v;
    bus.in_cdb_set_nzcv = setf; bus.in_cdb_nzcv = nz;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step(); @(posedge in_clk); #1; idle(); endtask
  task automatic half(); @(negedge in_clk); endtask

  always @(negedge in_clk) begin
    if (!in_rst && bus.out_issue_valid && bus.in_alu_ready) begin
      if (sb_q.size() == 0) chk("sb_unexpected_issue", 64'(sb_q.size()), 64'd1);
      else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("iss_dst",  64'(bus.out_issue_dst_tag), 64'(e.dst));
        chk("iss_op",   64'(bus.out_issue_op),      64'(e.op));
        chk("iss_a",    bus.out_issue_val_a,        e.a);
        chk("iss_b",    bus.out_issue_val_b,        e.b);
        chk("iss_nzcv", 64'(bus.out_issue_nzcv),    64'(e.nz));
        chk("iss_imms", 64'(bus.out_issue_imms),    64'(e.imms));
        chk("iss_immr", 64'(bus.out_issue_immr),    64'(e.immr));
        chk("iss_cond", 64'(bus.out_issue_cond),    64'(e.cond));
      end
    end
  end

  initial begin
    idle();
    bus.in_alu_ready = 1;
    in_rst = 1;
    repeat (3) @(posedge in_clk);
    #1 in_rst = 0;
    half();
    chk("rst_valid", 64'(bus.out_issue_valid), 64'd0);
    chk("rst_ready", 64'(bus.out_disp_ready), 64'd1);
    chk("rst_val_a", bus.out_issue_val_a, 64'd0);
    chk("rst_dst",   64'(bus.out_issue_dst_tag), 64'd0);
    step();

    // 1: fully ready micro-op, two-cycle latency.
    drv_disp(4'd3, 64'd5, 64'd7, 1, 4'd0, 1, 4'd0, 4'h9, 1, 4'd0);
    push_exp(4'd3, 64'd5, 64'd7, 4'h9);
    step(); half(); chk("t1_lat_n1", 64'(bus.out_issue_valid), 64'd0);
    step(); half(); chk("t1_lat_n2", 64'(bus.out_issue_valid), 64'd1);
    step(); step();

    // 2: younger ready entry overtakes an older waiting one.
    drv_disp(4'd1, 64'd0, 64'd2, 0, 4'd9, 1, 4'd0, 4'h0, 1, 4'd0);
    step();
    drv_disp(4'd2, 64'd3, 64'd4, 1, 4'd0, 1, 4'd0, 4'h1, 1, 4'd0);
    push_exp(4'd2, 64'd3, 64'd4, 4'h1);
    step();
    cdb(4'd9, 64'hAB, 0, 4'h0);
    push_exp(4'd1, 64'hAB, 64'd2, 4'h0);
    step(); half(); chk("t2_first", 64'(bus.out_issue_dst_tag), 64'd2);
    step(); half(); chk("t2_second", 64'(bus.out_issue_dst_tag), 64'd1);
    step(); step();

    // 3: fill the station, reject a dispatch, wake all four with one broadcast.
    for (int i = 0; i < 4; i++) begin
      drv_disp(4'(4 + i), 64'd0, 64'd0, 0, 4'd10, 0, 4'd10, 4'(i), 1, 4'd0);
      step();
    end
    drv_disp(4'd15, 64'hDEAD, 64'hBEEF, 1, 4'd0, 1, 4'd0, 4'h0, 1, 4'd0);
    half(); chk("t3_full", 64'(bus.out_disp_ready), 64'd0);
    step();
    cdb(4'd10, 64'h100, 0, 4'h0);
    for (int i = 0; i < 4; i++) push_exp(4'(4 + i), 64'h100, 64'h100, 4'(i));
    step(); half(); chk("t3_still_full", 64'(bus.out_disp_ready), 64'd0);
    step(); half(); chk("t3_ready_back", 64'(bus.out_disp_ready), 64'd1);
    chk("t3_oldest", 64'(bus.out_issue_dst_tag), 64'd4);
    repeat (5) step();
    chk("t3_drained", 64'(sb_q.size()), 64'd0);

    // 4: flags wakeup requires set_nzcv.
    drv_disp(4'd8, 64'h81, 64'h82, 1, 4'd0, 1, 4'd0, 4'hF, 0, 4'd5);
    step();
    cdb(4'd5, 64'h999, 0, 4'hF);
    step(); half(); chk("t4_no_wake_n2", 64'(bus.out_issue_valid), 64'd0);
    step();
    cdb(4'd5, 64'h999, 1, 4'b0100);
    push_exp(4'd8, 64'h81, 64'h82, 4'b0100);
    half(); chk("t4_no_wake_n3", 64'(bus.out_issue_valid), 64'd0);
    step(); half(); chk("t4_wait", 64'(bus.out_issue_valid), 64'd0);
    step(); half(); chk("t4_issue", 64'(bus.out_issue_valid), 64'd1);
    step(); step();

    // 5: ALU back-pressure holds the slot, release gives back-to-back issue.
    bus.in_alu_ready = 0;
    drv_disp(4'd9, 64'h11, 64'h12, 1, 4'd0, 1, 4'd0, 4'h2, 1, 4'd0);
    push_exp(4'd9, 64'h11, 64'h12, 4'h2);
    step();
    drv_disp(4'd10, 64'h22, 64'h23, 1, 4'd0, 1, 4'd0, 4'h3, 1, 4'd0);
    push_exp(4'd10, 64'h22, 64'h23, 4'h3);
    half(); chk("t5_empty", 64'(bus.out_issue_valid), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step(); half();
      chk("t5_hold_vld", 64'(bus.out_issue_valid), 64'd1);
      chk("t5_hold_dst", 64'(bus.out_issue_dst_tag), 64'd9);
      chk("t5_hold_a",   bus.out_issue_val_a, 64'h11);
    end
    step(); bus.in_alu_ready = 1;
    half(); chk("t5_rel_dst", 64'(bus.out_issue_dst_tag), 64'd9);
    step(); half();
    chk("t5_b2b_vld", 64'(bus.out_issue_valid), 64'd1);
    chk("t5_b2b_dst", 64'(bus.out_issue_dst_tag), 64'd10);
    step(); half(); chk("t5_idle", 64'(bus.out_issue_valid), 64'd0);
    step();

    // 6: dispatch bypass, then flush beats a same-cycle dispatch and clears the slot.
    drv_disp(4'd11, 64'd0, 64'h6B, 0, 4'd12, 1, 4'd0, 4'h4, 1, 4'd0);
    cdb(4'd12, 64'h5A5A, 0, 4'h0);
    push_exp(4'd11, 64'h5A5A, 64'h6B, 4'h4);
    step(); half(); chk("t6_byp_n1", 64'(bus.out_issue_valid), 64'd0);
    step(); half(); chk("t6_byp_n2", 64'(bus.out_issue_valid), 64'd1);
    step();
    bus.in_alu_ready = 0;
    drv_disp(4'd13, 64'h31, 64'h32, 1, 4'd0, 1, 4'd0, 4'h5, 1, 4'd0);
    step();
    drv_disp(4'd14, 64'h41, 64'h42, 1, 4'd0, 1, 4'd0, 4'h6, 1, 4'd0);
    step();
    in_flush = 1;
    drv_disp(4'd15, 64'h51, 64'h52, 1, 4'd0, 1, 4'd0, 4'h7, 1, 4'd0);
    half(); chk("t6_pre_flush", 64'(bus.out_issue_dst_tag), 64'd13);
    step(); bus.in_alu_ready = 1;
    half();
    chk("t6_flush_vld", 64'(bus.out_issue_valid), 64'd0);
    chk("t6_flush_a",   bus.out_issue_val_a, 64'd0);
    chk("t6_flush_rdy", 64'(bus.out_disp_ready), 64'd1);
    for (int i = 0; i < 3; i++) begin
      step(); half(); chk("t6_stay_empty", 64'(bus.out_issue_valid), 64'd0);
    end
    chk("sb_empty_end", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
